// File: rtl/e_muldiv_unit.sv
// E-stage multiply/divide unit for the five-stage MIPS pipeline: architectural HI/LO,
// results computed at issue, committed to HI/LO when the busy countdown expires.
module e_muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MD_Op,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    output logic [31:0] E_MD_Result,
    output logic        E_MD_Busy,
    output logic        E_MD_Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MULT_RUN = 2'd1,
        ST_DIV_RUN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      p_hi_q, p_hi_d;
    logic [31:0]      p_lo_q, p_lo_d;
    logic             p_keep_q, p_keep_d;

    // Multiply: sign/zero-extend to 64 bits so the low 64 product bits are exact.
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};
    assign prod_u = {32'd0, E_RS} * {32'd0, E_RT};

    // Divide: one unsigned divider on magnitudes, signs restored afterwards.
    logic        signed_div;
    logic        div_zero;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign signed_div = (E_MD_Op == OP_DIV);
    assign div_zero   = (E_RT == 32'd0);
    assign dvd_mag    = (signed_div && E_RS[31]) ? (32'd0 - E_RS) : E_RS;
    assign dvs_mag    = (signed_div && E_RT[31]) ? (32'd0 - E_RT) : E_RT;
    assign quo_mag    = div_zero ? 32'd0 : (dvd_mag / dvs_mag);
    assign rem_mag    = div_zero ? 32'd0 : (dvd_mag % dvs_mag);
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign quo = (signed_div && (E_RS[31] ^ E_RT[31])) ? (32'd0 - quo_mag) : quo_mag;
    assign rem = (signed_div && E_RS[31]) ? (32'd0 - rem_mag) : rem_mag;

    always_comb begin
        // NOTE: every _d is given its hold value first so no branch can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        p_keep_d = p_keep_q;

        case (state_q)
            ST_IDLE: begin
                case (E_MD_Op)
                    OP_MULT, OP_MULTU: begin
                        p_hi_d   = (E_MD_Op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                        p_lo_d   = (E_MD_Op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                        p_keep_d = 1'b0;
                        cnt_d    = MULT_LOAD;
                        busy_d   = 1'b1;
                        state_d  = ST_MULT_RUN;
                    end
                    OP_DIV, OP_DIVU: begin
                        p_hi_d   = rem;
                        p_lo_d   = quo;
                        p_keep_d = div_zero;
                        cnt_d    = DIV_LOAD;
                        busy_d   = 1'b1;
                        state_d  = ST_DIV_RUN;
                    end
                    OP_MTHI: hi_d = E_RS;
                    OP_MTLO: lo_d = E_RS;
                    default: ;
                endcase
            end
            ST_MULT_RUN, ST_DIV_RUN: begin
                // New ops are ignored here; only the countdown and commit happen.
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (!p_keep_q) begin
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only; all next-state decisions live in the always_comb.
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            p_hi_q   <= 32'd0;
            p_lo_q   <= 32'd0;
            p_keep_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            p_keep_q <= p_keep_d;
        end
    end

    always_comb begin
        E_MD_Result = 32'd0;
        if (E_MD_Op == OP_MFHI) E_MD_Result = hi_q;
        if (E_MD_Op == OP_MFLO) E_MD_Result = lo_q;
    end

    assign E_MD_Busy  = busy_q;
    assign E_MD_Stall = busy_q || ((E_MD_Op >= OP_MULT) && (E_MD_Op <= OP_DIVU));
    assign HI         = hi_q;
    assign LO         = lo_q;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Self-checking bench for e_muldiv_unit: directed cases plus random ops against a
// reference model built from 64-bit integer arithmetic.
module tb_e_muldiv_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op_in;
    logic [31:0] rs_in;
    logic [31:0] rt_in;
    logic [31:0] md_result;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

    e_muldiv_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_MD_Op    (op_in),
        .E_RS       (rs_in),
        .E_RT       (rt_in),
        .E_MD_Result(md_result),
        .E_MD_Busy  (md_busy),
        .E_MD_Stall (md_stall),
        .HI         (hi_out),
        .LO         (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural effect of one op issued while idle.
    task automatic model_apply(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint a;
        longint b;
        logic [63:0] r64;
        case (op)
            4'd1: begin
                r64  = 64'(longint'($signed(rs)) * longint'($signed(rt)));
                hi_m = r64[63:32];
                lo_m = r64[31:0];
            end
            4'd2: begin
                r64  = {32'd0, rs} * {32'd0, rt};
                hi_m = r64[63:32];
                lo_m = r64[31:0];
            end
            4'd3: if (rt != 32'd0) begin
                a    = longint'($signed(rs));
                b    = longint'($signed(rt));
                r64  = 64'(a / b);
                lo_m = r64[31:0];
                r64  = 64'(a % b);
                hi_m = r64[31:0];
            end
            4'd4: if (rt != 32'd0) begin
                lo_m = rs / rt;
                hi_m = rs % rt;
            end
            4'd7: hi_m = rs;
            4'd8: lo_m = rs;
            default: ;
        endcase
    endtask

    function automatic int busy_len(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return MULT_N;
        if (op == 4'd3 || op == 4'd4) return DIV_N;
        return 0;
    endfunction

    // Issue one op from idle, check combinational outputs, wait out busy, check HI/LO.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt);
        int n_busy;
        logic [31:0] exp_res;
        op_in = op;
        rs_in = rs;
        rt_in = rt;
        #1;
        exp_res = (op == 4'd5) ? hi_m : ((op == 4'd6) ? lo_m : 32'd0);
        check({tag, ".result"}, md_result, exp_res);
        check({tag, ".stall"}, 32'(md_stall), 32'(busy_len(op) != 0));
        model_apply(op, rs, rt);
        tick();
        op_in = 4'd0;
        n_busy = 0;
        while (md_busy === 1'b1 && n_busy < 64) begin
            n_busy++;
            tick();
        end
        check({tag, ".busy_cycles"}, 32'(n_busy), 32'(busy_len(op)));
        check({tag, ".hi"}, hi_out, hi_m);
        check({tag, ".lo"}, lo_out, lo_m);
    endtask

    initial begin
        int n_busy;
        int seen_busy;
        logic [3:0]  r_op;
        logic [31:0] r_rs;
        logic [31:0] r_rt;

        reset = 1'b0;
        op_in = 4'd0;
        rs_in = 32'd0;
        rt_in = 32'd0;
        hi_m  = 32'd0;
        lo_m  = 32'd0;

        // Reset state
        tick();
        tick();
        check("reset.hi", hi_out, 32'd0);
        check("reset.lo", lo_out, 32'd0);
        check("reset.busy", 32'(md_busy), 32'd0);
        check("reset.result", md_result, 32'd0);
        check("reset.stall", 32'(md_stall), 32'd0);
        reset = 1'b1;

        // Signed and unsigned multiply, mfhi readback
        run_op("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_neg.hi_const", hi_out, 32'hFFFF_FFFF);
        check("mult_neg.lo_const", lo_out, 32'hFFFF_FFFA);
        run_op("mfhi", 4'd5, 32'd0, 32'd0);
        run_op("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max.hi_const", hi_out, 32'hFFFF_FFFE);
        check("multu_max.lo_const", lo_out, 32'h0000_0001);

        // Divide cases, divide-by-zero and the overflow corner
        run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_neg.lo_const", lo_out, 32'hFFFF_FFFD);
        check("div_neg.hi_const", hi_out, 32'hFFFF_FFFF);
        run_op("divu_zero", 4'd4, 32'd7, 32'd0);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf.lo_const", lo_out, 32'h8000_0000);
        check("div_ovf.hi_const", hi_out, 32'd0);
        run_op("div_zero", 4'd3, 32'h1234, 32'd0);

        // Moves to/from HI/LO
        run_op("mthi", 4'd7, 32'h1234_5678, 32'd0);
        run_op("mfhi2", 4'd5, 32'd0, 32'd0);
        check("mfhi2.const", hi_out, 32'h1234_5678);
        run_op("mtlo", 4'd8, 32'hCAFE_F00D, 32'd0);
        run_op("mflo", 4'd6, 32'd0, 32'd0);
        run_op("op_undef", 4'd13, 32'h5555, 32'd9);

        // mtlo issued during busy cycle 3 is ignored
        op_in = 4'd3; rs_in = 32'd100; rt_in = 32'd7;
        model_apply(4'd3, 32'd100, 32'd7);
        tick();
        op_in = 4'd0;
        tick();
        tick();
        op_in = 4'd8; rs_in = 32'h0000_AAAA;
        #1;
        check("ignore.stall", 32'(md_stall), 32'd1);
        tick();
        op_in = 4'd0;
        n_busy = 3;
        while (md_busy === 1'b1 && n_busy < 64) begin
            n_busy++;
            tick();
        end
        check("ignore.busy_cycles", 32'(n_busy), 32'(DIV_N));
        check("ignore.lo", lo_out, 32'd14);
        check("ignore.hi", hi_out, 32'd2);

        // Reset during busy cycle 4 discards the pending result
        op_in = 4'd3; rs_in = 32'd100; rt_in = 32'd7;
        tick();
        op_in = 4'd0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        hi_m = 32'd0;
        lo_m = 32'd0;
        check("midreset.busy", 32'(md_busy), 32'd0);
        check("midreset.hi", hi_out, 32'd0);
        check("midreset.lo", lo_out, 32'd0);
        seen_busy = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (md_busy !== 1'b0) seen_busy++;
        end
        check("midreset.no_late_busy", 32'(seen_busy), 32'd0);
        check("midreset.hi_late", hi_out, 32'd0);
        check("midreset.lo_late", lo_out, 32'd0);

        // Back-to-back multiplies: second accepted in T+6
        op_in = 4'd1; rs_in = 32'd3; rt_in = 32'd4;
        tick();
        op_in = 4'd0;
        repeat (4) tick();
        check("b2b.busy_t5", 32'(md_busy), 32'd1);
        tick();
        check("b2b.busy_t6", 32'(md_busy), 32'd0);
        check("b2b.lo_t6", lo_out, 32'd12);
        op_in = 4'd1; rs_in = 32'd5; rt_in = 32'd6;
        tick();
        op_in = 4'd0;
        check("b2b.busy_t7", 32'(md_busy), 32'd1);
        repeat (4) tick();
        check("b2b.busy_t11", 32'(md_busy), 32'd1);
        tick();
        check("b2b.lo_t12", lo_out, 32'd30);
        check("b2b.busy_t12", 32'(md_busy), 32'd0);
        hi_m = 32'd0;
        lo_m = 32'd30;

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            r_op = 4'($urandom_range(1, 12));
            r_rs = $urandom;
            r_rt = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                r_rs = 32'h8000_0000;
                r_rt = 32'hFFFF_FFFF;
            end
            run_op("rand", r_op, r_rs, r_rt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

endmodule
